// File: rtl/wb_stage_if.sv
// mem_stage -> wb_stage handshake: valid/allowin pair plus the instruction payload.
interface wb_stage_if #(
    parameter int MS_TO_WS_BUS_WD = 168
);
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;

    modport master (
        input  ws_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus
    );

    modport slave (
        output ws_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle into the RF/CSR file,
// raises exception/ertn flushes, and drives the decode bypass and trace port.
module wb_stage #(
    parameter int MS_TO_WS_BUS_WD = 168,
    parameter int WS_FORWARD_WD   = 39
) (
    input  logic                     clk,
    input  logic                     resetn,
    wb_stage_if.slave                ms2ws,
    output logic [WS_FORWARD_WD-1:0] ws_forward,
    output logic [13:0]              csr_num,
    input  logic [31:0]              csr_rvalue,
    output logic                     csr_we,
    output logic [31:0]              csr_wmask,
    output logic [31:0]              csr_wdata,
    output logic                     excp_flush,
    output logic                     ertn_flush,
    output logic [5:0]               wb_ecode,
    output logic [8:0]               wb_esubcode,
    output logic [31:0]              wb_pc,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic [31:0]              debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [4:0]               debug_wb_rf_wnum,
    output logic [31:0]              debug_wb_rf_wdata
);
    typedef struct packed {
        logic [31:0] pc;
        logic        op_ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        res_from_csr;
        logic [31:0] final_result;
        logic        excp;
        logic [15:0] excp_num;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } ws_bus_t;

    logic                       ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] bus_r;
    ws_bus_t                    f;
    logic                       ex;
    logic [31:0]                result;

    assign ms2ws.ws_allowin = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            bus_r    <= '0;
        end else begin
            ws_valid <= ms2ws.ms_to_ws_valid;
            if (ms2ws.ms_to_ws_valid) begin
                bus_r <= ms2ws.ms_to_ws_bus;
            end
        end
    end

    assign f      = bus_r;
    assign ex     = ws_valid & f.excp;
    assign result = f.res_from_csr ? csr_rvalue : f.final_result;

    assign excp_flush = ex;
    assign ertn_flush = ws_valid & f.op_ertn & ~f.excp;

    assign rf_we     = ws_valid & f.gr_we & ~f.excp;
    assign rf_waddr  = f.dest;
    assign rf_wdata  = result;
    assign csr_we    = ws_valid & f.csr_we & ~f.excp;
    assign csr_num   = f.csr_num;
    assign csr_wmask = f.csr_wmask;
    assign csr_wdata = f.csr_wdata;
    assign wb_pc     = f.pc;

    // Lowest set excp_num bit selects the cause; any reserved bit alone maps to 0x3F.
    always_comb begin
        wb_ecode = '0;
        if (ex) begin
            if      (f.excp_num[0])       wb_ecode = 6'h00;
            else if (f.excp_num[1])       wb_ecode = 6'h08;
            else if (f.excp_num[2])       wb_ecode = 6'h0B;
            else if (f.excp_num[3])       wb_ecode = 6'h0C;
            else if (f.excp_num[4])       wb_ecode = 6'h0D;
            else if (f.excp_num[5])       wb_ecode = 6'h09;
            else if (|f.excp_num[15:6])   wb_ecode = 6'h3F;
        end
    end
    assign wb_esubcode = '0;

    assign ws_forward = {ws_valid, f.gr_we & ~f.excp, f.dest, result};

    assign debug_wb_pc       = f.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = f.dest;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table plus reset and back-to-back sequences.
module tb_wb_stage;
    logic        clk;
    logic        resetn;
    logic [38:0] ws_forward;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int errors = 0;
    int checks = 0;

    wb_stage_if #(.MS_TO_WS_BUS_WD(168)) bus_if ();

    wb_stage #(.MS_TO_WS_BUS_WD(168), .WS_FORWARD_WD(39)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms2ws             (bus_if),
        .ws_forward        (ws_forward),
        .csr_num           (csr_num),
        .csr_rvalue        (csr_rvalue),
        .csr_we            (csr_we),
        .csr_wmask         (csr_wmask),
        .csr_wdata         (csr_wdata),
        .excp_flush        (excp_flush),
        .ertn_flush        (ertn_flush),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .wb_pc             (wb_pc),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        gr_we;
        logic        rfc;
        logic [31:0] fres;
        logic        excp;
        logic [15:0] exnum;
        logic        cwe;
        logic [13:0] cnum;
        logic [31:0] cmask;
        logic [31:0] cdata;
        logic [31:0] rvalue;
        logic        e_valid;
        logic        e_rf_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_csr_we;
        logic        e_excp;
        logic        e_ertn;
        logic [5:0]  e_ecode;
        logic [31:0] e_pc;
        logic        e_fwd_we;
        logic [13:0] e_cnum;
        logic [31:0] e_cmask;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [167:0] pack(input vec_t v);
        return {v.pc, v.ertn, v.dest, v.gr_we, v.rfc, v.fres, v.excp, v.exnum,
                v.cwe, v.cnum, v.cmask, v.cdata};
    endfunction

    function automatic vec_t alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] data);
        vec_t v;
        v = '{1'b1, pc, 1'b0, dest, 1'b1, 1'b0, data, 1'b0, 16'h0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0,
              1'b1, 1'b1, dest, data, 1'b0, 1'b0, 1'b0, 6'h0, pc, 1'b1, 14'h0, 32'h0};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        bus_if.ms_to_ws_valid = v.valid;
        bus_if.ms_to_ws_bus   = pack(v);
        csr_rvalue            = v.rvalue;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // inputs: valid pc ertn dest gr_we rfc fres excp exnum cwe cnum cmask cdata rvalue
        // expect: valid rf_we waddr wdata csr_we excp ertn ecode pc fwd_we cnum cmask
        vecs[0]  = '{1, 32'h1C000010, 0, 5'd5, 1, 0, 32'hDEADBEEF, 0, 16'h0000, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 6'h00, 32'h1C000010, 1, 14'h000, 32'h0};
        vecs[1]  = '{1, 32'h1C000014, 0, 5'd4, 1, 1, 32'h0, 0, 16'h0000, 0, 14'h005, 32'h0, 32'h0, 32'h12345678,
                     1, 1, 5'd4, 32'h12345678, 0, 0, 0, 6'h00, 32'h1C000014, 1, 14'h005, 32'h0};
        vecs[2]  = '{1, 32'h1C000018, 0, 5'd4, 1, 1, 32'h0, 0, 16'h0000, 1, 14'h005, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h12345678,
                     1, 1, 5'd4, 32'h12345678, 1, 0, 0, 6'h00, 32'h1C000018, 1, 14'h005, 32'hFFFFFFFF};
        vecs[3]  = '{1, 32'h1C000020, 0, 5'd7, 1, 0, 32'h11111111, 1, 16'h0024, 1, 14'h044, 32'h0000FFFF, 32'h5A5A5A5A, 32'h0,
                     1, 0, 5'd7, 32'h11111111, 0, 1, 0, 6'h0B, 32'h1C000020, 0, 14'h044, 32'h0000FFFF};
        vecs[4]  = '{0, 32'hBAD00000, 1, 5'd31, 1, 1, 32'hFFFFFFFF, 1, 16'h0001, 1, 14'h3FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                     0, 0, 5'd7, 32'h11111111, 0, 0, 0, 6'h00, 32'h1C000020, 0, 14'h044, 32'h0000FFFF};
        vecs[5]  = '{1, 32'h1C000030, 1, 5'd0, 0, 0, 32'h0, 0, 16'h0000, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd0, 32'h0, 0, 0, 1, 6'h00, 32'h1C000030, 0, 14'h000, 32'h0};
        vecs[6]  = '{1, 32'h1C000034, 1, 5'd0, 0, 0, 32'h0, 1, 16'h0010, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd0, 32'h0, 0, 1, 0, 6'h0D, 32'h1C000034, 0, 14'h000, 32'h0};
        vecs[7]  = '{1, 32'h1C000038, 0, 5'd3, 1, 0, 32'h33, 1, 16'h0003, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd3, 32'h33, 0, 1, 0, 6'h00, 32'h1C000038, 0, 14'h000, 32'h0};
        vecs[8]  = '{1, 32'h1C00003C, 0, 5'd0, 0, 0, 32'h0, 1, 16'h0002, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd0, 32'h0, 0, 1, 0, 6'h08, 32'h1C00003C, 0, 14'h000, 32'h0};
        vecs[9]  = '{1, 32'h1C000040, 0, 5'd0, 0, 0, 32'h0, 1, 16'h0008, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd0, 32'h0, 0, 1, 0, 6'h0C, 32'h1C000040, 0, 14'h000, 32'h0};
        vecs[10] = '{1, 32'h1C000044, 0, 5'd0, 0, 0, 32'h0, 1, 16'h8020, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd0, 32'h0, 0, 1, 0, 6'h09, 32'h1C000044, 0, 14'h000, 32'h0};
        vecs[11] = '{1, 32'h1C000048, 0, 5'd0, 0, 0, 32'h0, 1, 16'h0400, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd0, 32'h0, 0, 1, 0, 6'h3F, 32'h1C000048, 0, 14'h000, 32'h0};
        vecs[12] = '{1, 32'h1C00004C, 0, 5'd0, 0, 0, 32'h0, 1, 16'h0000, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 0, 5'd0, 32'h0, 0, 1, 0, 6'h00, 32'h1C00004C, 0, 14'h000, 32'h0};
        vecs[13] = '{1, 32'h1C000050, 0, 5'd9, 1, 0, 32'h99, 0, 16'h0004, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 1, 5'd9, 32'h99, 0, 0, 0, 6'h00, 32'h1C000050, 1, 14'h000, 32'h0};
        vecs[14] = '{1, 32'h1C000054, 0, 5'd0, 1, 0, 32'hCAFEF00D, 0, 16'h0000, 0, 14'h000, 32'h0, 32'h0, 32'h0,
                     1, 1, 5'd0, 32'hCAFEF00D, 0, 0, 0, 6'h00, 32'h1C000054, 1, 14'h000, 32'h0};

        resetn                = 1'b0;
        bus_if.ms_to_ws_valid = 1'b1;
        bus_if.ms_to_ws_bus   = '1;
        csr_rvalue            = '0;
        #12;
        check("reset ws_valid", ws_forward[38], 1'b0);
        check("reset rf_we", rf_we, 1'b0);
        check("reset excp_flush", excp_flush, 1'b0);
        check("reset ertn_flush", ertn_flush, 1'b0);
        check("reset csr_we", csr_we, 1'b0);
        check("reset wb_pc", wb_pc, 32'h0);
        @(negedge clk);
        resetn                = 1'b1;
        bus_if.ms_to_ws_valid = 1'b0;
        check("post-reset ws_allowin", bus_if.ws_allowin, 1'b1);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            check($sformatf("v%0d ws_valid", i), ws_forward[38], vecs[i].e_valid);
            check($sformatf("v%0d rf_we", i), rf_we, vecs[i].e_rf_we);
            check($sformatf("v%0d rf_waddr", i), rf_waddr, vecs[i].e_waddr);
            check($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d csr_we", i), csr_we, vecs[i].e_csr_we);
            check($sformatf("v%0d csr_num", i), csr_num, vecs[i].e_cnum);
            check($sformatf("v%0d csr_wmask", i), csr_wmask, vecs[i].e_cmask);
            check($sformatf("v%0d excp_flush", i), excp_flush, vecs[i].e_excp);
            check($sformatf("v%0d ertn_flush", i), ertn_flush, vecs[i].e_ertn);
            check($sformatf("v%0d wb_ecode", i), wb_ecode, vecs[i].e_ecode);
            check($sformatf("v%0d wb_esubcode", i), wb_esubcode, 9'h0);
            check($sformatf("v%0d wb_pc", i), wb_pc, vecs[i].e_pc);
            check($sformatf("v%0d debug_wb_pc", i), debug_wb_pc, vecs[i].e_pc);
            check($sformatf("v%0d debug_wb_rf_we", i), debug_wb_rf_we, {4{vecs[i].e_rf_we}});
            check($sformatf("v%0d debug_wb_rf_wnum", i), debug_wb_rf_wnum, vecs[i].e_waddr);
            check($sformatf("v%0d debug_wb_rf_wdata", i), debug_wb_rf_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d fwd_ctl", i), ws_forward[38:32], {vecs[i].e_valid, vecs[i].e_fwd_we, vecs[i].e_waddr});
            check($sformatf("v%0d fwd_result", i), ws_forward[31:0], vecs[i].e_wdata);
            check($sformatf("v%0d ws_allowin", i), bus_if.ws_allowin, 1'b1);
        end

        // Back-to-back retires followed by a bubble that must hold the last payload.
        drive(alu(32'h1C0000A0, 5'd1, 32'h00000001));
        check("b2b0 rf_we", rf_we, 1'b1);
        check("b2b0 rf_wdata", rf_wdata, 32'h00000001);
        drive(alu(32'h1C0000A4, 5'd2, 32'h00000002));
        check("b2b1 rf_we", rf_we, 1'b1);
        check("b2b1 rf_waddr", rf_waddr, 5'd2);
        drive(alu(32'h1C0000A8, 5'd3, 32'h00000003));
        check("b2b2 rf_we", rf_we, 1'b1);
        check("b2b2 rf_wdata", rf_wdata, 32'h00000003);
        v = alu(32'h0BAD0BAD, 5'd30, 32'hFFFF0000);
        v.valid = 1'b0;
        drive(v);
        check("bubble rf_we", rf_we, 1'b0);
        check("bubble ws_valid", ws_forward[38], 1'b0);
        check("bubble hold rf_wdata", rf_wdata, 32'h00000003);
        check("bubble hold wb_pc", wb_pc, 32'h1C0000A8);

        // Asynchronous reset asserted mid-cycle while an exception sits in WB.
        v = alu(32'h1C0000C0, 5'd6, 32'h66666666);
        v.excp  = 1'b1;
        v.exnum = 16'h0004;
        drive(v);
        check("pre-reset excp_flush", excp_flush, 1'b1);
        check("pre-reset wb_ecode", wb_ecode, 6'h0B);
        #1 resetn = 1'b0;
        #1;
        check("async reset ws_valid", ws_forward[38], 1'b0);
        check("async reset excp_flush", excp_flush, 1'b0);
        check("async reset ertn_flush", ertn_flush, 1'b0);
        check("async reset rf_we", rf_we, 1'b0);
        check("async reset wb_pc", wb_pc, 32'h0);
        @(posedge clk);
        #1;
        check("held reset ws_valid", ws_forward[38], 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        check("release ws_allowin", bus_if.ws_allowin, 1'b1);
        drive(alu(32'h1C0000D0, 5'd8, 32'h88888888));
        check("after reset rf_we", rf_we, 1'b1);
        check("after reset rf_wdata", rf_wdata, 32'h88888888);
        check("after reset wb_pc", wb_pc, 32'h1C0000D0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
